// File: rtl/store_queue_drain_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_queue_drain_unit_pkg
// Description : Shared types for the retired-store drain path: LSQ block
//               widths, drain FSM state encoding and the D-cache request.
// Revision    : 1.0 - initial release
// ============================================================================
package store_queue_drain_unit_pkg;

    // Widths owned by the load/store unit; the drain unit follows them.
    localparam int LSQ_BLOCK_ADDR_WIDTH = 28;
    localparam int LSQ_BLOCK_WORD_NUM   = 2;
    localparam int LSQ_WORD_WIDTH       = 32;
    localparam int LSQ_BYTE_WE_WIDTH    = 4;

    typedef logic [LSQ_BLOCK_ADDR_WIDTH-1:0]                lsq_block_addr_t;
    typedef logic [LSQ_WORD_WIDTH*LSQ_BLOCK_WORD_NUM-1:0]   lsq_block_data_t;
    typedef logic [LSQ_BLOCK_WORD_NUM-1:0]                  lsq_word_we_t;
    typedef logic [LSQ_BYTE_WE_WIDTH-1:0]                   lsq_byte_we_t;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_REQ  = 2'd1,
        DRAIN_WAIT = 2'd2,
        DRAIN_MISS = 2'd3
    } drain_state_t;

    typedef struct packed {
        lsq_block_addr_t addr;
        lsq_block_data_t data;
        lsq_word_we_t    wordWE;
        lsq_byte_we_t    byteWE;
    } drain_req_t;

    // Index width of a table with 'depth' entries; a single entry still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_drain_ptr_counter.sv
`default_nettype none
// ============================================================================
// Module      : store_drain_ptr_counter
// Description : Retired-store read pointer (wraps at ENTRY_NUM, which need not
//               be a power of two) and the count of committed, undrained stores.
// Revision    : 1.0 - initial release
// ============================================================================
module store_drain_ptr_counter
    import store_queue_drain_unit_pkg::*;
#(
    parameter  int ENTRY_NUM    = 16,
    parameter  int COMMIT_WIDTH = 2,
    localparam int PTR_W        = ptr_width(ENTRY_NUM),
    localparam int PEND_W       = $clog2(ENTRY_NUM + 1),
    localparam int CNT_W        = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  i_commitNum,
    input  logic              i_pop,
    output logic [PTR_W-1:0]  o_readPtr,
    output logic [PEND_W-1:0] o_pending
);

    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(ENTRY_NUM - 1);

    logic [PTR_W-1:0]  r_readPtr;
    logic [PEND_W-1:0] r_pending;
    logic [PEND_W:0]   w_sum;

    // One spare bit so an overflow or underflow is visible rather than wrapped.
    assign w_sum = {1'b0, r_pending} + (PEND_W+1)'(i_commitNum) - (PEND_W+1)'(i_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_readPtr <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_sum[PEND_W-1:0];
            if (i_pop) begin
                r_readPtr <= (r_readPtr == c_LAST_PTR) ? '0 : r_readPtr + PTR_W'(1);
            end
        end
    end

    assign o_readPtr = r_readPtr;
    assign o_pending = r_pending;

`ifndef SYNTHESIS
    a_pending_bound: assert property (@(posedge clk) disable iff (rst)
        w_sum <= (PEND_W+1)'(ENTRY_NUM));
`endif

endmodule
`default_nettype wire

// File: rtl/store_queue_drain_unit.sv
`default_nettype none
// ============================================================================
// Module      : store_queue_drain_unit
// Description : Drains retired stores from the store queue head into the
//               D-cache write port, replaying on miss. Optional performance
//               counters are built when STORE_DRAIN_PERF_COUNTER_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module store_queue_drain_unit
    import store_queue_drain_unit_pkg::*;
#(
    parameter  int ENTRY_NUM        = 16,
    parameter  int COMMIT_WIDTH     = 2,
    parameter  int BLOCK_ADDR_WIDTH = LSQ_BLOCK_ADDR_WIDTH,
    parameter  int BLOCK_WORD_NUM   = LSQ_BLOCK_WORD_NUM,
    localparam int PTR_W            = ptr_width(ENTRY_NUM),
    localparam int PEND_W           = $clog2(ENTRY_NUM + 1),
    localparam int CNT_W            = $clog2(COMMIT_WIDTH + 1),
    localparam int DATA_W           = 32 * BLOCK_WORD_NUM
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CNT_W-1:0]            commitStoreNum,
    input  logic [PTR_W-1:0]            storeQueueHeadPtr,
    output logic [PTR_W-1:0]            retiredStoreQueuePtr,
    input  logic [BLOCK_ADDR_WIDTH-1:0] retiredStoreLSQ_BlockAddr,
    input  logic [DATA_W-1:0]           retiredStoreData,
    input  logic [BLOCK_WORD_NUM-1:0]   retiredStoreWordWE,
    input  logic [3:0]                  retiredStoreByteWE,
    input  logic                        retiredStoreCondEnabled,
    output logic                        releaseStoreQueueHead,
    output logic [CNT_W-1:0]            releaseStoreQueueHeadEntryNum,
    output logic                        dcWriteValid,
    input  logic                        dcWriteReady,
    output logic [BLOCK_ADDR_WIDTH-1:0] dcWriteAddr,
    output logic [DATA_W-1:0]           dcWriteData,
    output logic [BLOCK_WORD_NUM-1:0]   dcWriteWordWE,
    output logic [3:0]                  dcWriteByteWE,
    input  logic                        dcWriteAck,
    input  logic                        dcWriteHit,
    input  logic                        dcMissRefilled,
    output logic                        storeDrained,
    output logic [31:0]                 perfMissCount,
    output logic [31:0]                 perfStallCycles
);

    drain_state_t      r_state;
    drain_state_t      w_state_next;
    drain_req_t        r_req;
    logic              w_pop;
    logic              w_capture;
    logic              w_hasPending;
    logic [PTR_W-1:0]  w_readPtr;
    logic [PEND_W-1:0] w_pending;

    store_drain_ptr_counter #(
        .ENTRY_NUM    (ENTRY_NUM),
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_ptr_counter (
        .clk         (clk),
        .rst         (rst),
        .i_commitNum (commitStoreNum),
        .i_pop       (w_pop),
        .o_readPtr   (w_readPtr),
        .o_pending   (w_pending)
    );

    assign w_hasPending = (w_pending != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DRAIN_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // IDLE looks only at the registered pending count, so a store committed
    // this cycle is first considered next cycle.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            DRAIN_IDLE: begin
                if (w_hasPending) begin
                    if (!retiredStoreCondEnabled) begin
                        w_pop = 1'b1;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_next = DRAIN_REQ;
                    end
                end
            end
            DRAIN_REQ: begin
                if (dcWriteReady) begin
                    w_state_next = DRAIN_WAIT;
                end
            end
            DRAIN_WAIT: begin
                if (dcWriteAck) begin
                    if (dcWriteHit) begin
                        w_pop        = 1'b1;
                        w_state_next = DRAIN_IDLE;
                    end else begin
                        w_state_next = DRAIN_MISS;
                    end
                end
            end
            DRAIN_MISS: begin
                if (dcMissRefilled) begin
                    w_state_next = DRAIN_REQ;
                end
            end
            default: begin
                w_state_next = DRAIN_IDLE;
            end
        endcase
    end

    // Request is held across REQ/WAIT/MISS so a miss replays the same write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= '0;
        end else if (w_capture) begin
            r_req.addr   <= retiredStoreLSQ_BlockAddr;
            r_req.data   <= retiredStoreData;
            r_req.wordWE <= retiredStoreWordWE;
            r_req.byteWE <= retiredStoreByteWE;
        end
    end

    assign retiredStoreQueuePtr          = w_readPtr;
    assign releaseStoreQueueHead         = w_pop;
    assign releaseStoreQueueHeadEntryNum = CNT_W'(w_pop);
    assign dcWriteValid                  = (r_state == DRAIN_REQ);
    assign dcWriteAddr                   = r_req.addr;
    assign dcWriteData                   = r_req.data;
    assign dcWriteWordWE                 = r_req.wordWE;
    assign dcWriteByteWE                 = r_req.byteWE;
    assign storeDrained                  = !w_hasPending && (r_state == DRAIN_IDLE);

`ifdef STORE_DRAIN_PERF_COUNTER_EN
    logic [31:0] r_perfMissCount;
    logic [31:0] r_perfStallCycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perfMissCount   <= '0;
            r_perfStallCycles <= '0;
        end else begin
            if ((r_state == DRAIN_WAIT) && dcWriteAck && !dcWriteHit) begin
                r_perfMissCount <= r_perfMissCount + 32'd1;
            end
            if (((r_state == DRAIN_REQ) && !dcWriteReady) || (r_state == DRAIN_MISS)) begin
                r_perfStallCycles <= r_perfStallCycles + 32'd1;
            end
        end
    end

    assign perfMissCount   = r_perfMissCount;
    assign perfStallCycles = r_perfStallCycles;
`else
    assign perfMissCount   = '0;
    assign perfStallCycles = '0;
`endif

`ifndef SYNTHESIS
    a_wait_needs_ack: assert property (@(posedge clk) disable iff (rst)
        (r_state == DRAIN_WAIT) |-> dcWriteAck);
    a_head_consistent: assert property (@(posedge clk) disable iff (rst)
        ((r_state == DRAIN_IDLE) && w_hasPending) |-> (w_readPtr == storeQueueHeadPtr));
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_queue_drain_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_queue_drain_unit
// Description : Directed scenarios plus random traffic against a transaction-
//               level model of the store queue, D-cache and drain ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_queue_drain_unit;

    localparam int EN   = 12;
    localparam int CW   = 2;
    localparam int AW   = 28;
    localparam int WN   = 2;
    localparam int PW   = 4;
    localparam int CNTW = 2;
    localparam int DW   = 32 * WN;

    localparam int PH_REQ  = 0;
    localparam int PH_ACK  = 1;
    localparam int PH_MISS = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [WN-1:0] wwe;
        logic [3:0]    bwe;
        bit            cond;
    } ent_t;

    logic            clk;
    logic            rst;
    logic [CNTW-1:0] commitStoreNum;
    logic [PW-1:0]   storeQueueHeadPtr;
    logic [PW-1:0]   retiredStoreQueuePtr;
    logic [AW-1:0]   retiredStoreLSQ_BlockAddr;
    logic [DW-1:0]   retiredStoreData;
    logic [WN-1:0]   retiredStoreWordWE;
    logic [3:0]      retiredStoreByteWE;
    logic            retiredStoreCondEnabled;
    logic            releaseStoreQueueHead;
    logic [CNTW-1:0] releaseStoreQueueHeadEntryNum;
    logic            dcWriteValid;
    logic            dcWriteReady;
    logic [AW-1:0]   dcWriteAddr;
    logic [DW-1:0]   dcWriteData;
    logic [WN-1:0]   dcWriteWordWE;
    logic [3:0]      dcWriteByteWE;
    logic            dcWriteAck;
    logic            dcWriteHit;
    logic            dcMissRefilled;
    logic            storeDrained;
    logic [31:0]     perfMissCount;
    logic [31:0]     perfStallCycles;

    store_queue_drain_unit #(
        .ENTRY_NUM        (EN),
        .COMMIT_WIDTH     (CW),
        .BLOCK_ADDR_WIDTH (AW),
        .BLOCK_WORD_NUM   (WN)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .commitStoreNum                (commitStoreNum),
        .storeQueueHeadPtr             (storeQueueHeadPtr),
        .retiredStoreQueuePtr          (retiredStoreQueuePtr),
        .retiredStoreLSQ_BlockAddr     (retiredStoreLSQ_BlockAddr),
        .retiredStoreData              (retiredStoreData),
        .retiredStoreWordWE            (retiredStoreWordWE),
        .retiredStoreByteWE            (retiredStoreByteWE),
        .retiredStoreCondEnabled       (retiredStoreCondEnabled),
        .releaseStoreQueueHead         (releaseStoreQueueHead),
        .releaseStoreQueueHeadEntryNum (releaseStoreQueueHeadEntryNum),
        .dcWriteValid                  (dcWriteValid),
        .dcWriteReady                  (dcWriteReady),
        .dcWriteAddr                   (dcWriteAddr),
        .dcWriteData                   (dcWriteData),
        .dcWriteWordWE                 (dcWriteWordWE),
        .dcWriteByteWE                 (dcWriteByteWE),
        .dcWriteAck                    (dcWriteAck),
        .dcWriteHit                    (dcWriteHit),
        .dcMissRefilled                (dcMissRefilled),
        .storeDrained                  (storeDrained),
        .perfMissCount                 (perfMissCount),
        .perfStallCycles               (perfStallCycles)
    );

    always #5 clk = ~clk;

    // Store queue storage, read combinationally at the DUT's pointer.
    ent_t sq [EN];
    always_comb begin
        retiredStoreLSQ_BlockAddr = sq[retiredStoreQueuePtr].addr;
        retiredStoreData          = sq[retiredStoreQueuePtr].data;
        retiredStoreWordWE        = sq[retiredStoreQueuePtr].wwe;
        retiredStoreByteWE        = sq[retiredStoreQueuePtr].bwe;
        retiredStoreCondEnabled   = sq[retiredStoreQueuePtr].cond;
    end

    // Reference model: committed-but-undrained stores in order, plus the
    // progress of the write for the oldest one.
    ent_t        st_q [$];
    int          sq_head;
    int          cyc;
    int          phase;
    int          req_from;
    int          refill_cnt;
    int unsigned m_miss;
    int unsigned m_stall;
    int          n_checks;
    int          n_errors;

    bit            k_rst;
    int            k_commit;
    int            k_cond_mode;
    bit            k_ready;
    bit            k_hit;
    int            k_refill;
    bit            k_addr_use;
    logic [AW-1:0] k_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        int   n;
        bit   has, ack, refill, exp_valid, exp_pop, was_empty;
        ent_t fr;
        ent_t ne [CW];
        @(negedge clk);
        rst = k_rst;
        n = k_rst ? 0 : k_commit;
        if (st_q.size() + n > EN) n = EN - st_q.size();
        for (int i = 0; i < n; i++) begin
            ne[i].addr = AW'($urandom);
            ne[i].data = {$urandom, $urandom};
            ne[i].wwe  = WN'($urandom);
            ne[i].bwe  = 4'($urandom);
            ne[i].cond = (k_cond_mode == 1) ? 1'b1 :
                         (k_cond_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (i == 0 && k_addr_use) ne[i].addr = k_addr;
            sq[(sq_head + st_q.size() + i) % EN] = ne[i];
        end
        commitStoreNum = CNTW'(n);
        has = (st_q.size() != 0);
        if (has) fr = st_q[0];
        else     fr = '{default: '0};
        ack    = has && fr.cond && (phase == PH_ACK);
        refill = has && fr.cond && (phase == PH_MISS) && (refill_cnt == 0);
        dcWriteAck        = ack;
        dcWriteHit        = k_hit;
        dcMissRefilled    = refill;
        dcWriteReady      = k_ready;
        storeQueueHeadPtr = PW'(sq_head);
        #1;
        exp_valid = has && fr.cond && (phase == PH_REQ) && (cyc >= req_from);
        exp_pop   = has && (fr.cond ? (ack && k_hit) : 1'b1);
        if (k_rst) begin
            st_q.delete();
            sq_head    = 0;
            phase      = PH_REQ;
            refill_cnt = 0;
            m_miss     = 0;
            m_stall    = 0;
        end else begin
            check("valid", dcWriteValid, exp_valid);
            check("pop", releaseStoreQueueHead, exp_pop);
            check("pop_num", releaseStoreQueueHeadEntryNum, exp_pop);
            check("drained", storeDrained, !has);
            check("rdptr", retiredStoreQueuePtr, sq_head);
            if (exp_valid) begin
                check("req_addr", dcWriteAddr, fr.addr);
                check("req_data", dcWriteData, fr.data);
                check("req_wwe", dcWriteWordWE, fr.wwe);
                check("req_bwe", dcWriteByteWE, fr.bwe);
            end
`ifdef STORE_DRAIN_PERF_COUNTER_EN
            check("perf_miss", perfMissCount, m_miss);
            check("perf_stall", perfStallCycles, m_stall);
`else
            check("perf_miss_off", perfMissCount, 0);
            check("perf_stall_off", perfStallCycles, 0);
`endif
            if (exp_valid && !k_ready) m_stall++;
            if (has && fr.cond && phase == PH_MISS) m_stall++;
            if (ack && !k_hit) m_miss++;
            if (has && fr.cond) begin
                if (exp_valid && k_ready) begin
                    phase = PH_ACK;
                end else if (ack && !k_hit) begin
                    phase      = PH_MISS;
                    refill_cnt = k_refill;
                end else if (phase == PH_MISS) begin
                    if (refill) begin
                        phase    = PH_REQ;
                        req_from = cyc + 1;
                    end else begin
                        refill_cnt--;
                    end
                end
            end
            was_empty = !has;
            if (exp_pop) begin
                void'(st_q.pop_front());
                sq_head = (sq_head + 1) % EN;
            end
            for (int i = 0; i < n; i++) st_q.push_back(ne[i]);
            // A new oldest store is captured next cycle and requested the one after.
            if ((exp_pop || was_empty) && st_q.size() != 0) begin
                phase    = PH_REQ;
                req_from = cyc + 2;
            end
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        clk = 1'b0; rst = 1'b1; commitStoreNum = '0; storeQueueHeadPtr = '0;
        dcWriteReady = 1'b0; dcWriteAck = 1'b0; dcWriteHit = 1'b0; dcMissRefilled = 1'b0;
        for (int i = 0; i < EN; i++) sq[i] = '{default: '0};
        n_checks = 0; n_errors = 0; cyc = 0; sq_head = 0; phase = PH_REQ;
        req_from = 0; refill_cnt = 0; m_miss = 0; m_stall = 0;
        k_rst = 1'b1; k_commit = 0; k_cond_mode = 1; k_ready = 1'b1; k_hit = 1'b1;
        k_refill = 0; k_addr_use = 1'b0; k_addr = '0;

        // Reset state
        tick(); tick();
        k_rst = 1'b0;
        tick();
        check("rst_addr", dcWriteAddr, 0);
        check("rst_data", dcWriteData, 0);
        check("rst_wwe", dcWriteWordWE, 0);
        check("rst_bwe", dcWriteByteWE, 0);

        // Single enabled store at 0x10, hit with ready high
        k_commit = 1; k_addr_use = 1'b1; k_addr = AW'(28'h10);
        tick();
        k_commit = 0; k_addr_use = 1'b0;
        repeat (4) tick();
        check("t1_ptr", retiredStoreQueuePtr, 1);
        check("t1_drained", storeDrained, 1);
        check("t1_addr_held", dcWriteAddr, 28'h10);

        // Two stores in one commit cycle
        k_commit = 2;
        tick();
        k_commit = 0;
        repeat (8) tick();
        check("t2_ptr", retiredStoreQueuePtr, 3);

        // Miss, refill 10 cycles after the miss ack, replay and hit
        base = m_miss;
        k_hit = 1'b0; k_refill = 9; k_commit = 1;
        tick();
        k_commit = 0;
        repeat (3) tick();
        k_hit = 1'b1;
        repeat (15) tick();
        check("t3_drained", storeDrained, 1);
`ifdef STORE_DRAIN_PERF_COUNTER_EN
        check("t3_perf_miss", perfMissCount, base + 1);
`endif

        // Suppressed stores up to pointer 11, then two across the wrap
        k_cond_mode = 2;
        for (int i = 0; i < 20 && sq_head + st_q.size() < EN - 1; i++) begin
            k_commit = 1;
            tick();
        end
        k_commit = 0;
        repeat (2) tick();
        check("t4_ptr11", retiredStoreQueuePtr, EN - 1);
        k_commit = 2;
        tick();
        k_commit = 0;
        repeat (3) tick();
        check("t4_ptr_wrap", retiredStoreQueuePtr, 1);

        // Ready held low for 5 request cycles
        k_cond_mode = 1;
        base = m_stall;
        k_commit = 1;
        tick();
        k_commit = 0; k_ready = 1'b0;
        repeat (6) tick();
        k_ready = 1'b1;
        repeat (4) tick();
`ifdef STORE_DRAIN_PERF_COUNTER_EN
        check("t5_perf_stall", perfStallCycles, base + 5);
`else
        check("t5_perf_stall_off", perfStallCycles, 0);
`endif

        // Reset while waiting for a refill
        k_hit = 1'b0; k_refill = 50; k_commit = 1;
        tick();
        k_commit = 0;
        for (int i = 0; i < 10 && phase != PH_MISS; i++) tick();
        tick();
        k_rst = 1'b1;
        tick();
        k_rst = 1'b0; k_hit = 1'b1;
        tick();
        check("t6_valid", dcWriteValid, 0);
        check("t6_drained", storeDrained, 1);
        check("t6_ptr", retiredStoreQueuePtr, 0);

        // Random traffic
        k_cond_mode = 0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 9);
            k_commit = (r < 6) ? 0 : (r < 9) ? 1 : 2;
            k_ready  = ($urandom_range(0, 3) != 0);
            k_hit    = ($urandom_range(0, 3) != 0);
            k_refill = $urandom_range(0, 5);
            k_rst    = ($urandom_range(0, 599) == 0);
            tick();
        end
        k_rst = 1'b0; k_commit = 0; k_ready = 1'b1; k_hit = 1'b1; k_refill = 0;
        for (int i = 0; i < 200 && st_q.size() != 0; i++) tick();
        tick();
        check("final_drained", storeDrained, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
